// File: rtl/vga_fml_arbiter.sv
// vga_fml_arbiter: shares one FML memory port between the VGA fetcher and
// the CPU Wishbone slave. Video reads pass straight through with absolute
// priority; CPU accesses are latched, issued in idle memory cycles and
// acknowledged with a single-cycle Wishbone-classic ack.
// Optional feature macro: VGA_FML_ARB_WRBUF_EN (one-entry posted write buffer).
module vga_fml_arbiter #(
   parameter int AW     = 17,
   parameter int DW     = 16,
   parameter int SW     = 2,
   parameter int RD_LAT = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          vid_stb_i,
   input  logic [AW-1:0] vid_adr_i,
   output logic [DW-1:0] vid_dat_o,
   input  logic          cpu_cyc_i,
   input  logic          cpu_stb_i,
   input  logic          cpu_we_i,
   input  logic [AW-1:0] cpu_adr_i,
   input  logic [SW-1:0] cpu_sel_i,
   input  logic [DW-1:0] cpu_dat_i,
   output logic [DW-1:0] cpu_dat_o,
   output logic          cpu_ack_o,
   output logic          mem_stb_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_adr_o,
   output logic [SW-1:0] mem_sel_o,
   output logic [DW-1:0] mem_dat_o,
   input  logic [DW-1:0] mem_dat_i
);

   localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, ACK} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          abort, abort_nxt;
   logic          wb_pend, wb_pend_nxt;
   logic          ack_q;
   logic          latch_en;
   logic          issue;
   logic          capture;

   logic [AW-1:0] lat_adr;
   logic          lat_we;
   logic [SW-1:0] lat_sel;
   logic [DW-1:0] lat_dat;

   // Next-state logic: video always wins, the CPU access waits in REQ for a free slot
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      abort_nxt   = abort;
      wb_pend_nxt = wb_pend;
      latch_en    = 1'b0;
      issue       = 1'b0;
      capture     = 1'b0;
      case (state)
         IDLE: begin
            if (cpu_cyc_i && cpu_stb_i) begin
               latch_en  = 1'b1;
               abort_nxt = 1'b0;
`ifdef VGA_FML_ARB_WRBUF_EN
               if (cpu_we_i) begin
                  wb_pend_nxt = 1'b1;
                  state_nxt   = ACK;
               end else begin
                  state_nxt = REQ;
               end
`else
               state_nxt = REQ;
`endif
            end
         end
         REQ: begin
            if (wb_pend) begin
               // posted write drains regardless of the CPU bus state
               if (!vid_stb_i) begin
                  issue       = 1'b1;
                  wb_pend_nxt = 1'b0;
                  state_nxt   = IDLE;
               end
            end else if (!cpu_cyc_i) begin
               state_nxt = IDLE;
            end else if (!vid_stb_i) begin
               issue = 1'b1;
               if (lat_we) begin
                  state_nxt = ACK;
               end else begin
                  cnt_nxt   = CW'(RD_LAT - 1);
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (!cpu_cyc_i) abort_nxt = 1'b1;
            if (cnt == '0) begin
               // the read word is consumed even for an abandoned cycle
               capture   = 1'b1;
               state_nxt = (abort || !cpu_cyc_i) ? IDLE : ACK;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         ACK: begin
            state_nxt = wb_pend ? REQ : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Control state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         abort   <= 1'b0;
         wb_pend <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         abort   <= abort_nxt;
         wb_pend <= wb_pend_nxt;
         ack_q   <= (state_nxt == ACK);
      end
   end

   // CPU request latch, loaded when a new access is accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_adr <= '0;
         lat_we  <= 1'b0;
         lat_sel <= '0;
         lat_dat <= '0;
      end else if (latch_en) begin
         lat_adr <= cpu_adr_i;
         lat_we  <= cpu_we_i;
         lat_sel <= cpu_sel_i;
         lat_dat <= cpu_dat_i;
      end
   end

   // CPU read data register, holds until the next read capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpu_dat_o <= '0;
      end else if (capture) begin
         cpu_dat_o <= mem_dat_i;
      end
   end

   assign cpu_ack_o = ack_q;
   assign vid_dat_o = mem_dat_i;

   // memory port mux: video is combinational so the fetcher keeps its fixed pipe timing
   assign mem_stb_o = vid_stb_i | issue;
   assign mem_we_o  = vid_stb_i ? 1'b0 : (issue & lat_we);
   assign mem_adr_o = vid_stb_i ? vid_adr_i : lat_adr;
   assign mem_sel_o = vid_stb_i ? {SW{1'b1}} : lat_sel;
   assign mem_dat_o = lat_dat;

endmodule
